// File: rtl/ami_pkg.sv
// Shared AXI definitions for the ami master.
// Contents:
//   ami_state_t    - master FSM states
//   BurstIncr      - AxBURST encoding for INCR
//   RespOkay       - xRESP OKAY
//   RespSlverr     - xRESP SLVERR
//   AxCacheDefault - AxCACHE driven on every request (bufferable, modifiable)
//   resp_max       - picks the more severe of two responses
package ami_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StWresp,
    StRaddr,
    StRdata
  } ami_state_t;

  localparam logic [1:0] BurstIncr      = 2'b01;
  localparam logic [1:0] RespOkay       = 2'b00;
  localparam logic [1:0] RespSlverr     = 2'b10;
  localparam logic [3:0] AxCacheDefault = 4'b0011;

  // Response encodings are ordered by severity, so a plain max works.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ami.sv
// AXI4 master interface.
// Turns single user read/write commands into one outstanding INCR burst at a time.
// Ports:
//   ACLK, ARESETn            - clock, async active-low reset
//   AW*/W*/B*                - AXI4 write address, data and response channels
//   AR*/R*                   - AXI4 read address and data channels
//   cmd_*                    - command handshake: write/read, byte address, beats-1
//   usr_w*                   - write beat stream, forwarded to W during the data phase
//   usr_r*                   - read beat stream, forwarded from R during the data phase
//   done, resp               - one-cycle completion pulse with worst-case response
//   err                      - one-cycle pulse when a command would cross a 4KB boundary
module ami
  import ami_pkg::*;
#(
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 40,
  parameter int unsigned AXI_IW     = 8,
  parameter int unsigned AXI_LW     = 8,
  parameter int unsigned AXI_SW     = 3,
  parameter int unsigned AXI_BURSTW = 2,
  parameter int unsigned AXI_BRESPW = 2,
  parameter int unsigned AXI_RRESPW = 2,
  parameter int unsigned AMI_ID     = 0,
  parameter int unsigned AXI_BYTES  = AXI_DW / 8,
  parameter int unsigned AXI_WSTRBW = AXI_BYTES
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // write address
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [AXI_LW-1:0]     AWLEN,
  output logic [AXI_SW-1:0]     AWSIZE,
  output logic [AXI_BURSTW-1:0] AWBURST,
  output logic [3:0]            AWCACHE,
  output logic [2:0]            AWPROT,
  output logic [3:0]            AWQOS,
  output logic [3:0]            AWREGION,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // write data
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_WSTRBW-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // write response
  input  logic [AXI_IW-1:0]     BID,
  input  logic [AXI_BRESPW-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // read address
  output logic [AXI_IW-1:0]     ARID,
  output logic [AXI_AW-1:0]     ARADDR,
  output logic [AXI_LW-1:0]     ARLEN,
  output logic [AXI_SW-1:0]     ARSIZE,
  output logic [AXI_BURSTW-1:0] ARBURST,
  output logic [3:0]            ARCACHE,
  output logic [2:0]            ARPROT,
  output logic [3:0]            ARQOS,
  output logic [3:0]            ARREGION,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // read data
  input  logic [AXI_IW-1:0]     RID,
  input  logic [AXI_DW-1:0]     RDATA,
  input  logic [AXI_RRESPW-1:0] RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  // user command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [AXI_LW-1:0]     cmd_len,
  // user write beats
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_WSTRBW-1:0] usr_wstrb,
  input  logic                  usr_wvalid,
  output logic                  usr_wready,
  // user read beats
  output logic [AXI_DW-1:0]     usr_rdata,
  output logic [1:0]            usr_rresp,
  output logic                  usr_rlast,
  output logic                  usr_rvalid,
  input  logic                  usr_rready,
  // status
  output logic                  done,
  output logic [1:0]            resp,
  output logic                  err
);

  localparam int unsigned AddrLsb = $clog2(AXI_BYTES);

  ami_state_t        state_q, state_d;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_LW-1:0] len_q;
  logic [AXI_LW-1:0] cnt_q;
  logic [1:0]        rmax_q;
  logic              rbad_q;
  logic              done_q;
  logic [1:0]        resp_q;
  logic              err_q;
  logic              out_en_q;

  logic              cmd_acc;
  logic              cross_4k;
  logic [AXI_AW-1:0] addr_aligned;
  logic [13:0]       span_end;
  logic              w_hs, b_hs, r_hs;
  logic              cnt_at_len;
  logic [1:0]        rresp_2b;
  logic              unused_inputs;

  assign unused_inputs = ^{BID, RID};

  assign rresp_2b   = 2'(RRESP);
  assign cnt_at_len = (cnt_q == len_q);

  // cmd_ready stays low during reset and for the first cycle after release.
  assign cmd_ready = out_en_q && (state_q == StIdle);
  assign cmd_acc   = cmd_valid && cmd_ready;

  assign addr_aligned = cmd_addr & ~AXI_AW'(AXI_BYTES - 1);
  // 14 bits hold 4095 + 256*16 without wrap for the default configuration.
  assign span_end = 14'(addr_aligned[11:0]) + (14'(cmd_len) + 14'd1) * 14'(AXI_BYTES);
  assign cross_4k = (span_end > 14'd4096);

  assign w_hs = (state_q == StWdata) && usr_wvalid && WREADY;
  assign b_hs = (state_q == StWresp) && BVALID;
  assign r_hs = (state_q == StRdata) && RVALID && usr_rready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_acc && !cross_4k) state_d = cmd_write ? StWaddr : StRaddr;
      StWaddr: if (AWREADY) state_d = StWdata;
      StWdata: if (w_hs && cnt_at_len) state_d = StWresp;
      StWresp: if (BVALID) state_d = StIdle;
      StRaddr: if (ARREADY) state_d = StRdata;
      StRdata: if (r_hs && RLAST) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rmax_q   <= RespOkay;
      rbad_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= RespOkay;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_en_q <= 1'b1;
      err_q    <= cmd_acc && cross_4k;
      done_q   <= b_hs || (r_hs && RLAST);
      if (cmd_acc) begin
        addr_q <= addr_aligned;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        rmax_q <= RespOkay;
        rbad_q <= 1'b0;
      end else if (w_hs || r_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (r_hs) begin
        rmax_q <= resp_max(rmax_q, rresp_2b);
        // The beat that should have been last arrived without RLAST.
        if (!RLAST && cnt_at_len) rbad_q <= 1'b1;
      end
      if (b_hs) begin
        resp_q <= 2'(BRESP);
      end else if (r_hs && RLAST) begin
        resp_q <= (rbad_q || !cnt_at_len) ? RespSlverr : resp_max(rmax_q, rresp_2b);
      end
    end
  end

  // Write channels
  assign AWID     = AXI_IW'(AMI_ID);
  assign AWADDR   = addr_q;
  assign AWLEN    = len_q;
  assign AWSIZE   = AXI_SW'(AddrLsb);
  assign AWBURST  = AXI_BURSTW'(BurstIncr);
  assign AWCACHE  = AxCacheDefault;
  assign AWPROT   = 3'b000;
  assign AWQOS    = 4'b0000;
  assign AWREGION = 4'b0000;
  assign AWVALID  = (state_q == StWaddr);

  assign WDATA      = usr_wdata;
  assign WSTRB      = usr_wstrb;
  assign WVALID     = (state_q == StWdata) && usr_wvalid;
  assign WLAST      = (state_q == StWdata) && cnt_at_len;
  assign usr_wready = (state_q == StWdata) && WREADY;
  assign BREADY     = (state_q == StWresp);

  // Read channels
  assign ARID     = AXI_IW'(AMI_ID);
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = AXI_SW'(AddrLsb);
  assign ARBURST  = AXI_BURSTW'(BurstIncr);
  assign ARCACHE  = AxCacheDefault;
  assign ARPROT   = 3'b000;
  assign ARQOS    = 4'b0000;
  assign ARREGION = 4'b0000;
  assign ARVALID  = (state_q == StRaddr);

  assign usr_rdata  = RDATA;
  assign usr_rresp  = rresp_2b;
  assign usr_rlast  = (state_q == StRdata) && RLAST;
  assign usr_rvalid = (state_q == StRdata) && RVALID;
  assign RREADY     = (state_q == StRdata) && usr_rready;

  assign done = done_q;
  assign resp = resp_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ami.sv
// Directed bench for ami: write burst, delayed-ready read, stalled read with error beat,
// 4KB reject and boundary accept, RLAST protocol violations, and reset mid-burst.
module tb_ami;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awid, arid, bid, rid;
  logic [39:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst;
  logic [3:0]   awcache, awqos, awregion, arcache, arqos, arregion;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [127:0] wdata, rdata, usr_wdata, usr_rdata;
  logic [15:0]  wstrb, usr_wstrb;
  logic [1:0]   bresp, rresp, usr_rresp, resp;
  logic         bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [39:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic         usr_wvalid, usr_wready, usr_rlast, usr_rvalid, usr_rready;
  logic         done, err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ami dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWSIZE(awsize), .AWBURST(awburst),
    .AWCACHE(awcache), .AWPROT(awprot), .AWQOS(awqos), .AWREGION(awregion),
    .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WVALID(wvalid), .WREADY(wready),
    .BID(bid), .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
    .ARCACHE(arcache), .ARPROT(arprot), .ARQOS(arqos), .ARREGION(arregion),
    .ARVALID(arvalid), .ARREADY(arready),
    .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready),
    .usr_rdata(usr_rdata), .usr_rresp(usr_rresp), .usr_rlast(usr_rlast),
    .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .done(done), .resp(resp), .err(err)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Presents a command for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic w, input logic [39:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // AR handshake then nb unstalled beats, RLAST on beat last_at.
  task automatic run_read(input int nb, input int last_at);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      rvalid     = 1'b1;
      rdata      = 128'hBEEF_0000 + 128'(i);
      rresp      = 2'b00;
      rlast      = (i == last_at);
      usr_rready = 1'b1;
      #1;
      check_eq("rd_data", usr_rdata, 128'hBEEF_0000 + 128'(i));
      check_eq("rd_last", usr_rlast, (i == last_at));
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    int beat;
    int cyc;
    logic rv, ur;

    rst_n = 1'b0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    usr_wdata = 0; usr_wstrb = 0; usr_wvalid = 1; usr_rready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_wlast", wlast, 0);
    check_eq("rst_bready", bready, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_resp", resp, 0);
    usr_wvalid = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", cmd_ready, 1);

    // Write 0x100 len 3, immediate AWREADY, WREADY always 1
    issue(1'b1, 40'h100, 8'd3);
    check_eq("w_awvalid", awvalid, 1);
    check_eq("w_awaddr", awaddr, 40'h100);
    check_eq("w_awlen", awlen, 3);
    check_eq("w_awsize", awsize, 4);
    check_eq("w_awburst", awburst, 1);
    check_eq("w_awcache", awcache, 4'b0011);
    check_eq("w_cmd_ready", cmd_ready, 0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    check_eq("w_awvalid_drop", awvalid, 0);
    for (int i = 0; i < 4; i++) begin
      usr_wvalid = 1'b1;
      usr_wdata  = {4{32'h1111_0000 + 32'(i)}};
      usr_wstrb  = 16'hFFFF;
      wready     = 1'b1;
      #1;
      check_eq("w_wvalid", wvalid, 1);
      check_eq("w_wdata", wdata, {4{32'h1111_0000 + 32'(i)}});
      check_eq("w_wlast", wlast, (i == 3));
      @(negedge clk);
    end
    usr_wvalid = 1'b0;
    wready     = 1'b0;
    check_eq("w_bready", bready, 1);
    check_eq("w_early_done", done, 0);
    bvalid = 1'b1;
    bresp  = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    check_eq("w_done", done, 1);
    check_eq("w_resp", resp, 0);
    check_eq("w_ready_again", cmd_ready, 1);
    @(negedge clk);
    check_eq("w_done_pulse", done, 0);

    // Read 0x1F0 len 0, ARREADY delayed 5 cycles
    issue(1'b0, 40'h1F0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq("r1_arvalid", arvalid, 1);
      check_eq("r1_araddr", araddr, 40'h1F0);
      @(negedge clk);
    end
    check_eq("r1_arlen", arlen, 0);
    run_read(1, 0);
    check_eq("r1_done", done, 1);
    check_eq("r1_resp", resp, 0);

    // Read len 7 with SLVERR on beat 3 and RVALID/usr_rready stalls
    issue(1'b0, 40'h2000, 8'd7);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 64) begin
      rv         = (cyc % 3) != 1;
      ur         = (cyc % 4) != 2;
      rvalid     = rv;
      rdata      = 128'hA000 + 128'(beat);
      rresp      = (beat == 3) ? 2'b10 : 2'b00;
      rlast      = (beat == 7);
      usr_rready = ur;
      #1;
      if (rv && ur) begin
        check_eq("r3_data", usr_rdata, 128'hA000 + 128'(beat));
        beat++;
      end else if (rv) begin
        check_eq("r3_stall_rready", rready, 0);
      end
      cyc++;
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    check_eq("r3_beats", beat, 8);
    check_eq("r3_done", done, 1);
    check_eq("r3_resp", resp, 2'b10);

    // 4KB reject: 0xFF0 + 2*16 = 4112
    issue(1'b1, 40'hFF0, 8'd1);
    check_eq("x_err", err, 1);
    check_eq("x_awvalid", awvalid, 0);
    check_eq("x_arvalid", arvalid, 0);
    check_eq("x_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check_eq("x_err_pulse", err, 0);
    check_eq("x_awvalid2", awvalid, 0);

    // Exactly at the boundary: 0xFE0 + 2*16 = 4096, accepted
    issue(1'b0, 40'hFE0, 8'd1);
    check_eq("b_err", err, 0);
    check_eq("b_arvalid", arvalid, 1);
    check_eq("b_araddr", araddr, 40'hFE0);
    run_read(2, 1);
    check_eq("b_done", done, 1);
    check_eq("b_resp", resp, 0);

    // Early RLAST on beat 1 of a len-3 read
    issue(1'b0, 40'h300, 8'd3);
    run_read(2, 1);
    check_eq("e_done", done, 1);
    check_eq("e_resp", resp, 2'b10);
    check_eq("e_ready", cmd_ready, 1);

    // Missing RLAST at the last beat of a len-1 read, RLAST arrives one beat late
    issue(1'b0, 40'h305, 8'd1);
    check_eq("m_araddr_align", araddr, 40'h300);
    run_read(3, 2);
    check_eq("m_done", done, 1);
    check_eq("m_resp", resp, 2'b10);

    // Reset asserted in the middle of a write burst
    issue(1'b1, 40'h400, 8'd3);
    awready = 1'b1;
    @(negedge clk);
    awready    = 1'b0;
    usr_wvalid = 1'b1;
    wready     = 1'b1;
    @(negedge clk);
    #1;
    check_eq("a_wvalid", wvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("a_wvalid_rst", wvalid, 0);
    check_eq("a_usr_wready_rst", usr_wready, 0);
    check_eq("a_cmd_ready_rst", cmd_ready, 0);
    check_eq("a_wlast_rst", wlast, 0);
    check_eq("a_bready_rst", bready, 0);
    check_eq("a_resp_rst", resp, 0);
    usr_wvalid = 1'b0;
    wready     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("a_ready_after", cmd_ready, 1);
    check_eq("a_awvalid_after", awvalid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
